// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative HI/LO divider: state encodings and
// the constants used by div_unit and its single-iteration step.
package div_unit_pkg;

   localparam int DIV_WIDTH = 32;

   // Every quotient bit is set on divide-by-zero, whatever WIDTH is.
   localparam logic DIV_ZERO_QUO_BIT = 1'b1;

   typedef enum logic [1:0] {
      DivIdle = 2'd0,
      DivZero = 2'd1,
      DivBusy = 2'd2,
      DivDone = 2'd3
   } div_state_e;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift {rem, quo} left, then try to
// subtract the divisor magnitude from the remainder half.
module div_unit_step
   import div_unit_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [2*WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0]   divisor_i,
   output logic [2*WIDTH-1:0] acc_o
);

   logic [WIDTH:0]   upper;
   logic [WIDTH-1:0] diff;
   logic             fits;

   always_comb begin
      // Upper half after the shift keeps the bit shifted out of the remainder.
      upper = acc_i[2*WIDTH-1:WIDTH-1];
      fits  = upper >= {1'b0, divisor_i};
      diff  = upper[WIDTH-1:0] - divisor_i;
      acc_o = {(fits ? diff : upper[WIDTH-1:0]), acc_i[WIDTH-2:0], fits};
   end

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: quotient to LO, remainder to HI,
// with a one-cycle write strobe and a pipeline stall while busy.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             signed_i,
   input  logic             cancel_i,
   input  logic [WIDTH-1:0] opdata1_i,
   input  logic [WIDTH-1:0] opdata2_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             ready_o,
   output logic             stallreq_o
);

   localparam int CNT_W = $clog2(WIDTH);

   div_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d, step_acc;
   logic [WIDTH-1:0]   dvsr_q, dvsr_d, dvnd_q, dvnd_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic is_signed);
      return (is_signed && v[WIDTH-1]) ? -v : v;
   endfunction

   function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                   input logic neg);
      return neg ? -v : v;
   endfunction

   div_unit_step #(.WIDTH(WIDTH)) u_step (
      .acc_i     (acc_q),
      .divisor_i (dvsr_q),
      .acc_o     (step_acc)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      dvsr_d     = dvsr_q;
      dvnd_d     = dvnd_q;
      neg_quo_d  = neg_quo_q;
      neg_rem_d  = neg_rem_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      ready_o    = 1'b0;
      stallreq_o = 1'b0;

      case (state_q)
         DivIdle: begin
            stallreq_o = start_i;
            if (start_i) begin
               acc_d     = {{WIDTH{1'b0}}, magnitude(opdata1_i, signed_i)};
               dvsr_d    = magnitude(opdata2_i, signed_i);
               dvnd_d    = opdata1_i;
               neg_quo_d = signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
               neg_rem_d = signed_i & opdata1_i[WIDTH-1];
               cnt_d     = '0;
               state_d   = (opdata2_i == '0) ? DivZero : DivBusy;
            end
         end
         DivZero: begin
            stallreq_o = 1'b1;
            lo_d       = {WIDTH{DIV_ZERO_QUO_BIT}};
            hi_d       = dvnd_q;
            state_d    = DivDone;
         end
         DivBusy: begin
            stallreq_o = 1'b1;
            acc_d      = step_acc;
            cnt_d      = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               lo_d    = apply_sign(step_acc[WIDTH-1:0], neg_quo_q);
               hi_d    = apply_sign(step_acc[2*WIDTH-1:WIDTH], neg_rem_q);
               state_d = DivDone;
            end
         end
         DivDone: begin
            ready_o = 1'b1;
            state_d = DivIdle;
         end
         default: state_d = DivIdle;
      endcase

      // A flush wins over everything, including a start in the same cycle.
      if (cancel_i) begin
         state_d    = DivIdle;
         hi_d       = hi_q;
         lo_d       = lo_q;
         ready_o    = 1'b0;
         stallreq_o = 1'b0;
      end
      if (rst) begin
         ready_o    = 1'b0;
         stallreq_o = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= DivIdle;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_ff @(posedge clk) begin
      acc_q     <= acc_d;
      dvsr_q    <= dvsr_d;
      dvnd_q    <= dvnd_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule
